// File: rtl/key_event_scheduler.sv
// Key event scheduler: queues PS/2 key events and hands them one at a time to the matrix engine.
// Optional KEY_TYPEMATIC_FILTER_EN drops repeated makes of the last held key at the queue input.
module key_event_scheduler #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HOLD_TICKS = 64,
  parameter int unsigned HOLD_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_ena,
  input  logic                       flush,
  input  logic                       ev_valid,
  input  logic [9:0]                 ev_code,
  output logic                       upd_valid,
  input  logic                       upd_ready,
  output logic [9:0]                 upd_code,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned CODE_W = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   mem_q [DEPTH];
  logic [CODE_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic                upd_valid_q, upd_valid_d;
  logic [CODE_W-1:0]   upd_code_q, upd_code_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                pop, push, drop, full, filtered;

`ifdef KEY_TYPEMATIC_FILTER_EN
  logic                st_valid_q, st_valid_d;
  logic [CODE_W-2:0]   st_code_q, st_code_d;
`endif

  // Next-state: FIFO bookkeeping, dispatch FSM, sticky overflow, flush override
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    upd_valid_d = upd_valid_q;
    upd_code_d  = upd_code_q;
    overflow_d  = overflow_q;
`ifdef KEY_TYPEMATIC_FILTER_EN
    st_valid_d  = st_valid_q;
    st_code_d   = st_code_q;
    filtered    = ev_valid && !ev_code[9] && st_valid_q && (ev_code[8:0] == st_code_q);
`else
    filtered    = 1'b0;
`endif

    full = (level_q == LVL_W'(DEPTH));
    pop  = (state_q == ST_ISSUE) && upd_valid_q && upd_ready;
    push = ev_valid && !flush && !filtered && (!full || pop);
    drop = ev_valid && !flush && !filtered && full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = ev_code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end

`ifdef KEY_TYPEMATIC_FILTER_EN
    if (push && !ev_code[9]) begin
      st_valid_d = 1'b1;
      st_code_d  = ev_code[8:0];
    end else if (push && ev_code[9] && st_valid_q && (ev_code[8:0] == st_code_q)) begin
      st_valid_d = 1'b0;
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          state_d     = ST_ISSUE;
          upd_valid_d = 1'b1;
          upd_code_d  = mem_q[rd_ptr_q];
        end
      end
      ST_ISSUE: begin
        if (pop) begin
          upd_valid_d = 1'b0;
          if (HOLD_TICKS == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = HOLD_W'(HOLD_TICKS);
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (clk_ena) begin
          if (cnt_q <= HOLD_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    if (flush) begin
      state_d     = ST_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      cnt_d       = '0;
      upd_valid_d = 1'b0;
`ifdef KEY_TYPEMATIC_FILTER_EN
      st_valid_d  = 1'b0;
`endif
    end

    busy_d = (state_d != ST_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_code_q  <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef KEY_TYPEMATIC_FILTER_EN
      st_valid_q  <= 1'b0;
      st_code_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      upd_valid_q <= upd_valid_d;
      upd_code_q  <= upd_code_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
`ifdef KEY_TYPEMATIC_FILTER_EN
      st_valid_q  <= st_valid_d;
      st_code_q   <= st_code_d;
`endif
    end
  end

  // Queue storage needs no reset; occupancy tracking guards reads
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign upd_valid = upd_valid_q;
  assign upd_code  = upd_code_q;
  assign busy      = busy_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule
